// File: rtl/inst_fetch_q_if.sv
// Fetch-stage bus bundle: redirect, instruction-memory req/gnt/rvalid and ID handshake.
// master = the fetch stage, slave = the surrounding core/memory.
interface inst_fetch_q_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_exc;
   logic        id_ready;

   modport master (
      input  redirect_valid,
      input  redirect_pc,
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata,
      output if_valid,
      output if_pc,
      output if_instr,
      output if_exc,
      input  id_ready
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata,
      input  if_valid,
      input  if_pc,
      input  if_instr,
      input  if_exc,
      output id_ready
   );
endinterface

// File: rtl/inst_fetch_q.sv
// IF stage: owns the PC, issues imem requests, queues in-order responses for ID.
// Define IF_MISALIGN_CHK_EN to turn misaligned redirects into an if_exc marker entry.
module inst_fetch_q #(
   parameter logic [31:0] RESET_PC        = 32'h0040_0000,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic           clk,
   input  logic           rstn,
   inst_fetch_q_if.master fq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] LP_MAXO  = CW'(MAX_OUTSTANDING);

   logic [31:0]   r_pc;
   logic          r_live;
   logic [31:0]   r_fl_pc [DEPTH];
   logic [AW-1:0] r_fl_wr;
   logic [AW-1:0] r_fl_rd;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_discard;
   logic [31:0]   r_q_pc [DEPTH];
   logic [31:0]   r_q_instr [DEPTH];
   logic [AW-1:0] r_q_wr;
   logic [AW-1:0] r_q_rd;
   logic [CW-1:0] r_cnt;

   logic          w_redir;
   logic [31:0]   w_new_pc;
   logic          w_halt;
   logic [CW:0]   w_sum;
   logic          w_req;
   logic          w_fire;
   logic          w_resp;
   logic          w_keep;
   logic          w_exc_push;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;
   logic [31:0]   w_push_pc;
   logic [31:0]   w_push_instr;

`ifdef IF_MISALIGN_CHK_EN
   logic          r_halt;
   logic          r_exc_pend;
   logic          r_q_exc [DEPTH];
   logic          w_misalign;

   assign w_new_pc   = fq.redirect_pc;
   assign w_misalign = |fq.redirect_pc[1:0];
   assign w_halt     = r_halt;
   // Marker waits until every in-flight (now stale) response has drained.
   assign w_exc_push = r_exc_pend & ~w_redir & (r_out == '0)
                     & (r_cnt < LP_DEPTH);
`else
   assign w_new_pc   = fq.redirect_pc & 32'hFFFF_FFFC;
   assign w_halt     = 1'b0;
   assign w_exc_push = 1'b0;
`endif

   assign w_redir = fq.redirect_valid;
   assign w_sum   = {1'b0, r_out} + {1'b0, r_cnt};

   // Credit rule: every granted request already owns a queue slot.
   assign w_req  = r_live & ~w_redir & ~w_halt
                 & (r_out < LP_MAXO)
                 & (w_sum < {1'b0, LP_DEPTH});
   assign w_fire = w_req & fq.imem_gnt;

   // Orphan responses (nothing outstanding) are ignored.
   assign w_resp = fq.imem_rvalid & (r_out != '0);
   assign w_keep = w_resp & (r_discard == '0) & ~w_redir;

   assign w_push       = w_keep | w_exc_push;
   assign w_valid      = (r_cnt != '0);
   assign w_pop        = w_valid & fq.id_ready;
   assign w_push_pc    = w_exc_push ? r_pc : r_fl_pc[r_fl_rd];
   assign w_push_instr = w_exc_push ? 32'h0 : fq.imem_rdata;

   assign fq.imem_req  = w_req;
   assign fq.imem_addr = {r_pc[31:2], 2'b00};
   assign fq.if_valid  = w_valid;
   assign fq.if_pc     = w_valid ? r_q_pc[r_q_rd] : 32'h0;
   assign fq.if_instr  = w_valid ? r_q_instr[r_q_rd] : 32'h0;
`ifdef IF_MISALIGN_CHK_EN
   assign fq.if_exc    = w_valid & r_q_exc[r_q_rd];
`else
   assign fq.if_exc    = 1'b0;
`endif

   // Hold off fetching for the first cycle out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_live <= 1'b0;
      else       r_live <= 1'b1;
   end

   // PC: redirect reloads, a granted request advances by one word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       r_pc <= RESET_PC;
      else if (w_redir) r_pc <= w_new_pc;
      else if (w_fire)  r_pc <= r_pc + 32'd4;
   end

   // In-flight PC FIFO pointers: push on grant, pop on any response.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fl_wr <= '0;
         r_fl_rd <= '0;
      end else begin
         if (w_fire) r_fl_wr <= r_fl_wr + 1'b1;
         if (w_resp) r_fl_rd <= r_fl_rd + 1'b1;
      end
   end

   // In-flight PC storage.
   always_ff @(posedge clk) begin
      if (w_fire) r_fl_pc[r_fl_wr] <= r_pc;
   end

   // Outstanding request count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out <= '0;
      end else begin
         unique case ({w_fire, w_resp})
            2'b10:   r_out <= r_out + 1'b1;
            2'b01:   r_out <= r_out - 1'b1;
            default: r_out <= r_out;
         endcase
      end
   end

   // Stale-response count: everything still in flight at a redirect.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_discard <= '0;
      else if (w_redir)
         r_discard <= r_out - CW'(w_resp);
      else if (w_resp & (r_discard != '0))
         r_discard <= r_discard - 1'b1;
   end

   // Fetch queue pointers and occupancy; redirect flushes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q_wr <= '0;
         r_q_rd <= '0;
         r_cnt  <= '0;
      end else if (w_redir) begin
         r_q_wr <= '0;
         r_q_rd <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_q_wr <= r_q_wr + 1'b1;
         if (w_pop)  r_q_rd <= r_q_rd + 1'b1;
         if (w_push & ~w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (~w_push & w_pop)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   // Fetch queue storage.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_q_wr]    <= w_push_pc;
         r_q_instr[r_q_wr] <= w_push_instr;
      end
   end

`ifdef IF_MISALIGN_CHK_EN
   // Misaligned redirect halts fetch and arms a single marker entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_halt     <= 1'b0;
         r_exc_pend <= 1'b0;
      end else if (w_redir) begin
         r_halt     <= w_misalign;
         r_exc_pend <= w_misalign;
      end else if (w_exc_push) begin
         r_exc_pend <= 1'b0;
      end
   end

   // Marker flag storage alongside the queue.
   always_ff @(posedge clk) begin
      if (w_push) r_q_exc[r_q_wr] <= w_exc_push;
   end
`endif

   // A response with nothing outstanding is a memory protocol error.
   a_rsp_has_req: assert property (
      @(posedge clk) disable iff (!rstn)
      fq.imem_rvalid |-> (r_out != '0)
   );

endmodule

// File: tb/tb_inst_fetch_q.sv
// Randomized bench for inst_fetch_q with a transaction-level reference model.
// Build with or without IF_MISALIGN_CHK_EN to match the RTL.
module tb_inst_fetch_q;
   localparam int          DEPTH  = 4;
   localparam int          MAXO   = 2;
   localparam logic [31:0] RST_PC = 32'h0040_0000;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } ent_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   inst_fetch_q_if fq ();

   inst_fetch_q #(
      .RESET_PC       (RST_PC),
      .DEPTH          (DEPTH),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .fq  (fq)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int epoch  = 0;
   int lat_min = 1;
   int lat_max = 1;
   int rv_pct  = 100;

   req_t pend[$];
   ent_t mq[$];

   logic [31:0] exp_pc   = RST_PC;
   bit          halted   = 1'b0;
   bit          exc_pend = 1'b0;

   bit          d_redir = 1'b0;
   logic [31:0] d_rpc   = 32'h0;
   bit          d_gnt   = 1'b0;
   bit          d_rdy   = 1'b0;

   bit          s_req, s_valid, s_fire, s_exc;
   logic [31:0] s_addr, s_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)",
                    tag, obs, exp, cyc);
   endtask

   task automatic drive_idle();
      fq.redirect_valid = 1'b0;
      fq.redirect_pc    = 32'h0;
      fq.imem_gnt       = 1'b0;
      fq.imem_rvalid    = 1'b0;
      fq.imem_rdata     = 32'h0;
      fq.id_ready       = 1'b0;
   endtask

   // One clock: drive at negedge, check and update the model, then posedge.
   task automatic tick();
      bit          rv;
      bit          exp_req;
      bit          exc_push;
      int          sz_q;
      int          sz_p;
      logic [31:0] rd;
      req_t        r;
      ent_t        e;
      @(negedge clk);
      rv = 1'b0;
      rd = $urandom;
      if (pend.size() != 0 && pend[0].due <= cyc &&
          $urandom_range(99) < rv_pct) begin
         rv = 1'b1;
         rd = mem_word(pend[0].addr);
      end
      fq.redirect_valid = d_redir;
      fq.redirect_pc    = d_rpc;
      fq.imem_gnt       = d_gnt;
      fq.id_ready       = d_rdy;
      fq.imem_rvalid    = rv;
      fq.imem_rdata     = rd;
      #1;
      sz_q = mq.size();
      sz_p = pend.size();
      exp_req = !d_redir && !halted && sz_p < MAXO && sz_p + sz_q < DEPTH;
      check("imem_req", fq.imem_req, exp_req);
      if (exp_req) check("imem_addr", fq.imem_addr, exp_pc);
      check("if_valid", fq.if_valid, sz_q != 0);
      if (sz_q != 0) begin
         check("if_pc", fq.if_pc, mq[0].pc);
         check("if_instr", fq.if_instr, mq[0].instr);
         check("if_exc", fq.if_exc, mq[0].exc);
      end
      s_req   = fq.imem_req;
      s_addr  = fq.imem_addr;
      s_valid = fq.if_valid;
      s_pc    = fq.if_pc;
      s_exc   = fq.if_exc;
      s_fire  = fq.imem_req & d_gnt;

      exc_push = exc_pend && !d_redir && sz_p == 0 && sz_q < DEPTH;
      if (sz_q != 0 && d_rdy) void'(mq.pop_front());
      if (exp_req && d_gnt) begin
         r.addr = exp_pc;
         r.ep   = epoch;
         r.due  = cyc + $urandom_range(lat_max, lat_min);
         pend.push_back(r);
         exp_pc = exp_pc + 32'd4;
      end
      if (rv) begin
         r = pend.pop_front();
         if (r.ep == epoch && !d_redir) begin
            e.pc    = r.addr;
            e.instr = mem_word(r.addr);
            e.exc   = 1'b0;
            mq.push_back(e);
         end
      end
      if (exc_push) begin
         e.pc    = exp_pc;
         e.instr = 32'h0;
         e.exc   = 1'b1;
         mq.push_back(e);
         exc_pend = 1'b0;
      end
      if (d_redir) begin
         mq.delete();
         epoch++;
`ifdef IF_MISALIGN_CHK_EN
         exp_pc   = d_rpc;
         halted   = (d_rpc[1:0] != 2'b00);
         exc_pend = halted;
`else
         exp_pc = {d_rpc[31:2], 2'b00};
`endif
      end
      @(posedge clk);
      cyc++;
   endtask

   // Asynchronous reset asserted away from any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rstn = 1'b0;
      drive_idle();
      d_redir = 1'b0;
      d_gnt   = 1'b0;
      d_rdy   = 1'b0;
      #1;
      check("rst_req", fq.imem_req, 0);
      check("rst_valid", fq.if_valid, 0);
      check("rst_pc", fq.if_pc, 0);
      check("rst_instr", fq.if_instr, 0);
      check("rst_exc", fq.if_exc, 0);
      pend.delete();
      mq.delete();
      exp_pc   = RST_PC;
      halted   = 1'b0;
      exc_pend = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: %0d checks passed of %0d", n_pass, n_chk);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int          k;
      int          pops;
      logic [31:0] a0, a1, a2;
      drive_idle();
      do_reset();

      // Sequential fetch from reset, zero-wait memory
      d_gnt = 1; d_rdy = 1; lat_min = 1; lat_max = 1; rv_pct = 100;
      k = 0;
      a0 = '0; a1 = '0; a2 = '0;
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_fire) begin
            if (k == 0) a0 = s_addr;
            if (k == 1) a1 = s_addr;
            if (k == 2) a2 = s_addr;
            k++;
         end
         if (i >= 4 && s_valid) pops++;
      end
      check("t1_addr0", a0, 32'h0040_0000);
      check("t1_addr1", a1, 32'h0040_0004);
      check("t1_addr2", a2, 32'h0040_0008);
      check("t1_rate", pops, 16);

      // ID stalls: queue fills, fetching stops, then drains in order
      d_rdy = 0;
      for (int i = 0; i < 20; i++) tick();
      check("t2_valid", s_valid, 1);
      check("t2_req", s_req, 0);
      d_rdy = 1;
      for (int i = 0; i < 12; i++) tick();

      // Redirect with two requests in flight
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && pend.size() != 2; i++) tick();
      check("t3_inflight", pend.size(), 2);
      foreach (pend[i]) pend[i].due = cyc;
      lat_min = 1; lat_max = 1;
      d_redir = 1; d_rpc = 32'h0000_1000;
      tick();
      d_redir = 0;
      k = 0;
      a0 = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (s_valid && k == 0) begin
            k  = i;
            a0 = s_pc;
         end
      end
      check("t3_latency", k, 3);
      check("t3_first_pc", a0, 32'h0000_1000);

      // PC wrap at the top of the address space
      d_redir = 1; d_rpc = 32'hFFFF_FFFC;
      tick();
      d_redir = 0;
      k = 0;
      a0 = '1; a1 = '1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s_fire) begin
            if (k == 0) a0 = s_addr;
            if (k == 1) a1 = s_addr;
            k++;
         end
      end
      check("t4_addr0", a0, 32'hFFFF_FFFC);
      check("t4_addr1", a1, 32'h0000_0000);

      // Grant withheld: address must hold
      d_gnt = 0;
      tick();
      a0 = s_addr;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_addr_hold", s_addr, a0);
      end
      d_gnt = 1;
      a1 = '1;
      for (int i = 0; i < 6 && a1 == '1; i++) begin
         tick();
         if (s_fire) a1 = s_addr;
      end
      check("t5_next_addr", a1, a0);
      for (int i = 0; i < 6; i++) tick();

      // Misaligned redirect target
      d_redir = 1; d_rpc = 32'h0000_1002;
      tick();
      d_redir = 0;
      k = 0;
      pops = 0;
      a0 = '0; a1 = '0; a2 = '1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (s_fire) begin
            if (k == 0) a2 = s_addr;
            k++;
         end
         if (s_valid && pops == 0) begin
            pops = 1;
            a0 = s_pc;
            a1 = {31'h0, s_exc};
         end
      end
`ifdef IF_MISALIGN_CHK_EN
      check("t6_no_fetch", k, 0);
      check("t6_exc_pc", a0, 32'h0000_1002);
      check("t6_exc_flag", a1, 1);
`else
      check("t6_fetch_addr", a2, 32'h0000_1000);
      check("t6_first_pc", a0, 32'h0000_1000);
      check("t6_no_exc", a1, 0);
`endif
      d_redir = 1; d_rpc = 32'h0000_2000;
      tick();
      d_redir = 0;

      // Randomized traffic with redirects and one mid-run reset
      lat_min = 1; lat_max = 3; rv_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            d_gnt = 1;
            d_rdy = 1;
         end
         d_gnt = ($urandom_range(3) != 0);
         d_rdy = ($urandom_range(2) != 0);
         if (d_redir && $urandom_range(1) == 0) begin
            d_redir = 1;
         end else begin
            d_redir = ($urandom_range(99) < 3);
            d_rpc   = $urandom;
            if ($urandom_range(3) != 0) d_rpc[1:0] = 2'b00;
         end
         tick();
      end
      d_redir = 0;
      for (int i = 0; i < 10; i++) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
